// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM states and frame geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into 32-bit words; strobes word_valid with the
// completed word in the same cycle its fourth byte is accepted.
module word_packer
  import loader_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [31:0] r_shift;
  logic [31:0] w_shift_next;

  // Shifting in from the top leaves the first byte of a group in bits [7:0].
  assign w_shift_next = {i_byte, r_shift[31:8]};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'd0;
    end else if (i_clr) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'd0;
    end else if (i_byte_en) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= w_shift_next;
    end
  end

  assign o_word_valid = i_byte_en && (r_cnt == LAST_BYTE);
  assign o_word       = w_shift_next;

endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader: validates header/checksum, writes instruction memory
// one word at a time and holds the core in reset until a clean load completes.
module instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        load_req,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        IMemWE,
  output logic [31:0] IMemAddr,
  output logic [31:0] IMemWD,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_xor;
  logic [7:0]  r_cnt_lo;
  logic [15:0] r_count;
  logic [15:0] r_idx;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wd;

  logic        w_acc;
  logic        w_rearm;
  logic [15:0] w_count;
  logic [15:0] w_idx_inc;
  logic        w_word_valid;
  logic [31:0] w_word;

  assign byte_ready = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                      (r_state == ST_DATA) || (r_state == ST_CHK);
  assign w_acc      = byte_valid && byte_ready;
  assign w_rearm    = load_req && ((r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_count    = {byte_data, r_cnt_lo};
  assign w_idx_inc  = r_idx + 16'd1;

  word_packer u_packer (
    .CLK          (CLK),
    .reset        (reset),
    .i_clr        (w_rearm),
    .i_byte_en    (w_acc && (r_state == ST_DATA)),
    .i_byte       (byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= ST_HDR0;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HDR0: if (w_acc) w_state_next = ST_HDR1;
      ST_HDR1: begin
        if (w_acc) begin
          if (w_count > MAX_W)        w_state_next = ST_ERR;
          else if (w_count == 16'd0)  w_state_next = ST_CHK;
          else                        w_state_next = ST_DATA;
        end
      end
      ST_DATA: if (w_word_valid && (w_idx_inc == r_count)) w_state_next = ST_CHK;
      ST_CHK:  if (w_acc) w_state_next = (byte_data == r_xor) ? ST_DONE : ST_ERR;
      ST_DONE, ST_ERR: if (load_req) w_state_next = ST_HDR0;
      default: w_state_next = ST_HDR0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_xor    <= 8'd0;
      r_cnt_lo <= 8'd0;
      r_count  <= 16'd0;
      r_idx    <= 16'd0;
    end else if (w_rearm) begin
      r_xor <= 8'd0;
      r_idx <= 16'd0;
    end else begin
      if (w_acc && (r_state != ST_CHK)) r_xor <= r_xor ^ byte_data;
      if (w_acc && (r_state == ST_HDR0)) r_cnt_lo <= byte_data;
      if (w_acc && (r_state == ST_HDR1)) r_count <= w_count;
      if (w_word_valid) r_idx <= w_idx_inc;
    end
  end

  // Write port registers; address/data hold between strobes.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_addr <= BASE_ADDR;
      r_wd   <= 32'd0;
    end else begin
      r_we <= w_word_valid;
      if (w_word_valid) begin
        r_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
        r_wd   <= w_word;
      end
    end
  end

  assign IMemWE   = r_we;
  assign IMemAddr = r_addr;
  assign IMemWD   = r_wd;
  assign cpu_run  = (r_state == ST_DONE);
  assign done     = (r_state == ST_DONE);
  assign error    = (r_state == ST_ERR);

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that writes the instruction memory read by the processor's fetch/decode path. It accepts a byte stream over a valid/ready handshake, checks a small header and trailing checksum, packs bytes little-endian into 32-bit instruction words, and issues one memory write per word. It holds the processor core in reset until a load completes cleanly, then releases it. It sits between the board-level byte source (UART receiver) and the instruction memory write port.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first instruction word; must be word-aligned.
- `MAX_WORDS`, default 64: largest accepted word count; range 1..65535.
- `CLK` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; asserted when 0.
- `load_req` input 1: one-cycle pulse that re-arms the loader from DONE or ERR.
- `byte_data` input 8: stream byte.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_ready` output 1: loader accepts `byte_data` this cycle.
- `IMemWE` output 1: instruction memory write strobe, one cycle per word.
- `IMemAddr` output 32: byte address of the write.
- `IMemWD` output 32: instruction word to write.
- `cpu_run` output 1: 1 releases the core; 0 holds it in reset.
- `done` output 1: level, load finished with a good checksum.
- `error` output 1: level, load rejected.

## Operation
- Frame format: CNT_L, CNT_H (16-bit word count N, little-endian), then 4·N payload bytes, then CHK.
- CHK must equal the XOR of every preceding byte in the frame, including both count bytes.
- A byte transfers on any rising edge where `byte_valid && byte_ready`.
- States:
  - HDR0: accept CNT_L, then go to HDR1.
  - HDR1: accept CNT_H. If N > MAX_WORDS, go to ERR. If N == 0, go to CHK. Otherwise go to DATA.
  - DATA: accept payload bytes. The first byte of each group fills bits [7:0], the fourth fills bits [31:24]. After byte 4·N, go to CHK.
  - CHK: accept one byte. A match goes to DONE; a mismatch goes to ERR.
  - DONE and ERR: hold until `load_req`, which returns the loader to HDR0 and clears the running XOR, the word index and the packer.
- `byte_ready` is 1 in HDR0, HDR1, DATA and CHK, and 0 in DONE and ERR.
- Word k (0-based) is written to `BASE_ADDR + 4·k`.
- `IMemAddr` and `IMemWD` are registered and hold their last value when `IMemWE` is 0.
- `cpu_run` is 1 only in DONE. `done` is 1 only in DONE. `error` is 1 only in ERR.
- Words already written are not rolled back on ERR. The core stays held in reset.
- `load_req` outside DONE/ERR is ignored.
- Word index width is 16 bits. The address adder is 32 bits and wraps modulo 2^32.

## Timing
- Reset values: state HDR0, `byte_ready`=1, `IMemWE`=0, `IMemAddr`=BASE_ADDR, `IMemWD`=0, `cpu_run`=0, `done`=0, `error`=0, XOR=0, index=0.
- Reset asserted mid-frame aborts the frame immediately; the partial word is discarded.
- Write latency: `IMemWE` pulses in the cycle after the edge that accepts a word's fourth byte.
- Throughput: one byte per cycle, no bubbles. The packer refills while the previous word's write is in flight.
- State changes on the edge that accepts the deciding byte:
  - DONE/ERR and `cpu_run`/`done`/`error` are visible in the cycle after CHK is accepted.
  - The last word's `IMemWE` pulse coincides with the CHK-state cycle or occurs earlier.
  - ERR caused by an oversize count is visible in the cycle after CNT_H is accepted.
- `load_req` in DONE/ERR: the next cycle is HDR0 with `cpu_run`=0 and `byte_ready`=1.
- `byte_valid` low stalls every state with no side effects.

## Structure
- Shared package `loader_pkg`:
  - state enum (HDR0, HDR1, DATA, CHK, DONE, ERR);
  - header length 2;
  - bytes-per-word 4.
- Sub-module `word_packer`:
  - 2-bit byte counter and 32-bit shift register;
  - emits a one-cycle `word_valid` with the assembled word;
  - synchronous clear input driven by `load_req`.
- Top level holds the FSM, XOR accumulator, word index, address register and output registers.

## Test plan
- **Two-word load:** frame 02 00, then words E3A00005 and E2811001 (bytes 05 00 A0 E3 01 10 81 E2), then the correct CHK.
  - Writes to 0x00 and 0x04 with those values.
  - `done`=1 and `cpu_run`=1 one cycle after CHK.
- **Bad checksum:** same frame with CHK XOR 0x01.
  - Both writes still occur.
  - `error`=1, `cpu_run`=0 and `byte_ready`=0.
- **Oversize count:** with MAX_WORDS=64, send count 41 00 (65).
  - ERR the cycle after CNT_H is accepted.
  - No `IMemWE` pulse.
- **Empty frame and back-pressure:** send 00 00 00.
  - DONE with no writes.
  - Then pulse `load_req`: HDR0 next cycle with `cpu_run`=0.
  - Repeat a one-word load with `byte_valid` toggled every other cycle; the correct word lands at BASE_ADDR.
- **Reset mid-word:** assert `reset` after 2 payload bytes.
  - All outputs return to reset values asynchronously.
  - A fresh complete frame afterwards loads correctly from BASE_ADDR.
